// File: rtl/nchan_serializer.sv
// nchan_serializer: parameterised N-channel, W-bit parallel-to-serial converter.
// A frame (NUM_CH words plus a channel mask) is accepted on the input
// valid/ready handshake. Each enabled channel is then emitted as one beat on
// the output valid/ready handshake, from the lowest enabled channel upwards.
// One extra frame can wait in a holding register, so back-to-back frames
// stream with no bubble between them.
//
// Ports:
//   clk, reset          sole clock (rising edge), async active-high reset
//   in_valid/in_ready   input frame handshake
//   in_data             channel k at bits [k*WIDTH +: WIDTH]
//   ch_mask             per-frame channel enables, sampled with the frame
//   out_valid/out_ready output beat handshake
//   out_data, out_ch    current channel word and its index
//   out_first/out_last  first / last enabled channel of the frame
//   busy                active frame or held frame present
//   frames_sent         count of completed frames (wraps)
module nchan_serializer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8,
  localparam int unsigned CW    = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       ch_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CW-1:0]           out_ch,
  output logic                    out_first,
  output logic                    out_last,
  output logic                    busy,
  output logic [15:0]             frames_sent
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                  state_q, state_d;
  logic [NUM_CH*WIDTH-1:0] act_data_q, act_data_d;
  logic [NUM_CH-1:0]       act_mask_q, act_mask_d;
  logic [NUM_CH*WIDTH-1:0] hold_data_q, hold_data_d;
  logic [NUM_CH-1:0]       hold_mask_q, hold_mask_d;
  logic                    hold_full_q, hold_full_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic [15:0]             cnt_q, cnt_d;

  // Index of the lowest set bit (0 if none).
  function automatic logic [CW-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [CW-1:0] r;
    r = '0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      if (m[k]) r = CW'(k);
    end
    return r;
  endfunction

  // Index of the lowest set bit strictly above c (0 if none).
  function automatic logic [CW-1:0] next_set(input logic [NUM_CH-1:0] m,
                                             input logic [CW-1:0] c);
    logic [CW-1:0] r;
    r = '0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      if (m[k] && (k > int'(c))) r = CW'(k);
    end
    return r;
  endfunction

  // True if any bit above c is set.
  function automatic logic any_above(input logic [NUM_CH-1:0] m,
                                     input logic [CW-1:0] c);
    logic r;
    r = 1'b0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (m[k] && (k > int'(c))) r = 1'b1;
    end
    return r;
  endfunction

  logic sending;
  logic is_last;
  logic out_hs;
  logic accept;
  logic acc_live;

  assign sending  = (state_q == StSend);
  assign is_last  = !any_above(act_mask_q, ch_q);
  assign out_hs   = sending && out_ready;
  assign accept   = in_valid && !hold_full_q;
  // Mask-zero frames are consumed by the handshake but never stored.
  assign acc_live = accept && (|ch_mask);

  always_comb begin
    state_d     = state_q;
    act_data_d  = act_data_q;
    act_mask_d  = act_mask_q;
    hold_data_d = hold_data_q;
    hold_mask_d = hold_mask_q;
    hold_full_d = hold_full_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (acc_live) begin
          act_data_d = in_data;
          act_mask_d = ch_mask;
          ch_d       = lowest_set(ch_mask);
          state_d    = StSend;
        end
      end
      StSend: begin
        if (out_hs && is_last) begin
          cnt_d = cnt_q + 16'd1;
          if (hold_full_q) begin
            act_data_d  = hold_data_q;
            act_mask_d  = hold_mask_q;
            ch_d        = lowest_set(hold_mask_q);
            hold_full_d = 1'b0;
          end else if (acc_live) begin
            // Frame ending this cycle frees ACTIVE, so bypass HOLD.
            act_data_d = in_data;
            act_mask_d = ch_mask;
            ch_d       = lowest_set(ch_mask);
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (out_hs) ch_d = next_set(act_mask_q, ch_q);
          if (acc_live) begin
            hold_data_d = in_data;
            hold_mask_d = ch_mask;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      act_data_q  <= '0;
      act_mask_q  <= '0;
      hold_data_q <= '0;
      hold_mask_q <= '0;
      hold_full_q <= 1'b0;
      ch_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      act_data_q  <= act_data_d;
      act_mask_q  <= act_mask_d;
      hold_data_q <= hold_data_d;
      hold_mask_q <= hold_mask_d;
      hold_full_q <= hold_full_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (ch_q == CW'(k)) out_data = act_data_q[k*WIDTH +: WIDTH];
    end
  end

  assign in_ready    = !hold_full_q;
  assign out_valid   = sending;
  assign out_ch      = ch_q;
  assign out_first   = sending && (ch_q == lowest_set(act_mask_q));
  assign out_last    = sending && is_last;
  assign busy        = sending || hold_full_q;
  assign frames_sent = cnt_q;

endmodule

// File: tb/tb_nchan_serializer.sv
// Directed self-checking bench for nchan_serializer (NUM_CH=4, WIDTH=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_nchan_serializer;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int CW     = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       ch_mask;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [CW-1:0]           out_ch;
  logic                    out_first;
  logic                    out_last;
  logic                    busy;
  logic [15:0]             frames_sent;

  nchan_serializer #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .ch_mask    (ch_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_first  (out_first),
    .out_last   (out_last),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] fq_data[$];
  logic [3:0]  fq_mask[$];
  int          b_ch[$];
  logic [7:0]  b_data[$];
  logic        b_first[$];
  logic        b_last[$];
  int          b_cyc[$];
  int          acc_log[$];
  int          rdy_low;
  int          stall_bad;
  bit          timed_out;

  task automatic clear_logs();
    b_ch.delete(); b_data.delete(); b_first.delete(); b_last.delete();
    b_cyc.delete(); acc_log.delete();
    rdy_low = 0; stall_bad = 0; timed_out = 0;
  endtask

  // Offers queued frames, drives out_ready (stall_pct % low), logs beats.
  // Entered and left at posedge+1. Stops when drained, after stop_beats beats,
  // or after max_cyc cycles (flagging timed_out).
  task automatic run(input int max_cyc, input int stall_pct, input int stop_beats);
    int n;
    logic prev_stall;
    logic [7:0] pd;
    logic [CW-1:0] pc;
    n = 0; prev_stall = 1'b0; pd = '0; pc = '0;
    clear_logs();
    forever begin
      in_valid  = (fq_mask.size() > 0);
      in_data   = in_valid ? fq_data[0] : '0;
      ch_mask   = in_valid ? fq_mask[0] : '0;
      out_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
      @(negedge clk);
      cyc++; n++;
      if (prev_stall && ((out_data !== pd) || (out_ch !== pc))) stall_bad++;
      prev_stall = out_valid && !out_ready;
      pd = out_data; pc = out_ch;
      if (!in_ready) rdy_low++;
      if (out_valid && out_ready) begin
        b_ch.push_back(int'(out_ch)); b_data.push_back(out_data);
        b_first.push_back(out_first); b_last.push_back(out_last);
        b_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        void'(fq_data.pop_front()); void'(fq_mask.pop_front());
        acc_log.push_back(cyc);
      end
      @(posedge clk); #1;
      if (stop_beats > 0 && b_ch.size() >= stop_beats) break;
      if (fq_mask.size() == 0 && !busy) break;
      if (n >= max_cyc) begin timed_out = 1'b1; break; end
    end
    in_valid = 1'b0; in_data = '0; ch_mask = '0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; ch_mask = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data got %h want 00", out_data); end
    n_cmp++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL rst_out_ch got %0d want 0", out_ch); end
    n_cmp++; if ({out_first, out_last} !== 2'b00) begin n_fail++; $display("FAIL rst_first_last got %b want 00", {out_first, out_last}); end
    n_cmp++; if (frames_sent !== 16'h0000) begin n_fail++; $display("FAIL rst_frames got %h want 0000", frames_sent); end
    reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [7:0] exp_d [4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    fq_data.push_back(32'h44332211); fq_mask.push_back(4'hF);
    run(50, 0, 0);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL single_timeout got 1 want 0"); end
    n_cmp++; if (b_ch.size() != 4) begin n_fail++; $display("FAIL single_beats got %0d want 4", b_ch.size()); end
    n_cmp++; if (acc_log.size() != 1 || b_cyc.size() == 0 || b_cyc[0] != acc_log[0] + 1) begin
      n_fail++; $display("FAIL single_latency got beats=%0d want first beat one cycle after accept", b_cyc.size()); end
    for (int i = 0; i < 4 && i < b_ch.size(); i++) begin
      n_cmp++;
      if (b_ch[i] != i || b_data[i] !== exp_d[i] || b_first[i] !== (i == 0) ||
          b_last[i] !== (i == 3) || b_cyc[i] != b_cyc[0] + i) begin
        n_fail++;
        $display("FAIL single_beat%0d got ch=%0d d=%h f=%b l=%b want ch=%0d d=%h f=%b l=%b",
                 i, b_ch[i], b_data[i], b_first[i], b_last[i], i, exp_d[i], i == 0, i == 3);
      end
    end
    n_cmp++; if (frames_sent !== 16'd1) begin n_fail++; $display("FAIL single_frames got %0d want 1", frames_sent); end
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got v=%b b=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_mask1010();
    logic [15:0] f0;
    f0 = frames_sent;
    fq_data.push_back(32'hD4C3B2A1); fq_mask.push_back(4'b1010);
    run(50, 0, 0);
    n_cmp++; if (b_ch.size() != 2) begin n_fail++; $display("FAIL m1010_beats got %0d want 2", b_ch.size()); end
    if (b_ch.size() == 2) begin
      n_cmp++; if (b_ch[0] != 1 || b_data[0] !== 8'hB2 || b_first[0] !== 1'b1 || b_last[0] !== 1'b0) begin
        n_fail++; $display("FAIL m1010_b0 got ch=%0d d=%h f=%b l=%b want ch=1 d=b2 f=1 l=0", b_ch[0], b_data[0], b_first[0], b_last[0]); end
      n_cmp++; if (b_ch[1] != 3 || b_data[1] !== 8'hD4 || b_first[1] !== 1'b0 || b_last[1] !== 1'b1) begin
        n_fail++; $display("FAIL m1010_b1 got ch=%0d d=%h f=%b l=%b want ch=3 d=d4 f=0 l=1", b_ch[1], b_data[1], b_first[1], b_last[1]); end
      n_cmp++; if (b_cyc[1] != b_cyc[0] + 1) begin n_fail++; $display("FAIL m1010_gap got %0d want 1", b_cyc[1] - b_cyc[0]); end
    end
    n_cmp++; if (frames_sent !== f0 + 16'd1) begin n_fail++; $display("FAIL m1010_frames got %0d want %0d", frames_sent, f0 + 16'd1); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] f0;
    logic [7:0] ed;
    f0 = frames_sent;
    fq_data.push_back(32'h04030201); fq_mask.push_back(4'hF);
    fq_data.push_back(32'h14131211); fq_mask.push_back(4'hF);
    fq_data.push_back(32'h24232221); fq_mask.push_back(4'hF);
    run(100, 0, 0);
    n_cmp++; if (b_ch.size() != 12) begin n_fail++; $display("FAIL b2b_beats got %0d want 12", b_ch.size()); end
    for (int i = 0; i < 12 && i < b_ch.size(); i++) begin
      ed = 8'((i / 4) * 16 + (i % 4) + 1);
      n_cmp++;
      if (b_ch[i] != i % 4 || b_data[i] !== ed || b_first[i] !== (i % 4 == 0) ||
          b_last[i] !== (i % 4 == 3) || b_cyc[i] != b_cyc[0] + i) begin
        n_fail++;
        $display("FAIL b2b_beat%0d got ch=%0d d=%h cyc+%0d want ch=%0d d=%h cyc+%0d",
                 i, b_ch[i], b_data[i], b_cyc[i] - b_cyc[0], i % 4, ed, i);
      end
    end
    n_cmp++; if (rdy_low != 6) begin n_fail++; $display("FAIL b2b_in_ready_low got %0d want 6", rdy_low); end
    n_cmp++; if (acc_log.size() != 3 || acc_log[2] != acc_log[0] + 5) begin
      n_fail++; $display("FAIL b2b_third_wait got accepts=%0d want third at +5", acc_log.size()); end
    n_cmp++; if (frames_sent !== f0 + 16'd3) begin n_fail++; $display("FAIL b2b_frames got %0d want %0d", frames_sent, f0 + 16'd3); end
  endtask

  task automatic test_stall();
    logic [15:0] f0;
    logic [7:0] exp_d [4];
    exp_d = '{8'h8D, 8'h7C, 8'h6B, 8'h5A};
    f0 = frames_sent;
    fq_data.push_back(32'h5A6B7C8D); fq_mask.push_back(4'hF);
    run(300, 50, 0);
    n_cmp++; if (timed_out) begin n_fail++; $display("FAIL stall_timeout got 1 want 0"); end
    n_cmp++; if (stall_bad != 0) begin n_fail++; $display("FAIL stall_stable got %0d changes want 0", stall_bad); end
    n_cmp++; if (b_ch.size() != 4) begin n_fail++; $display("FAIL stall_beats got %0d want 4", b_ch.size()); end
    for (int i = 0; i < 4 && i < b_ch.size(); i++) begin
      n_cmp++;
      if (b_ch[i] != i || b_data[i] !== exp_d[i]) begin
        n_fail++; $display("FAIL stall_beat%0d got ch=%0d d=%h want ch=%0d d=%h", i, b_ch[i], b_data[i], i, exp_d[i]);
      end
    end
    n_cmp++; if (frames_sent !== f0 + 16'd1) begin n_fail++; $display("FAIL stall_frames got %0d want %0d", frames_sent, f0 + 16'd1); end
  endtask

  task automatic test_zero_mask();
    logic [15:0] f0;
    f0 = frames_sent;
    fq_data.push_back(32'h33221100); fq_mask.push_back(4'hF);
    fq_data.push_back(32'hFFFFFFFF); fq_mask.push_back(4'h0);
    fq_data.push_back(32'h77665544); fq_mask.push_back(4'hF);
    run(100, 0, 0);
    n_cmp++; if (acc_log.size() != 3) begin n_fail++; $display("FAIL zmask_accepts got %0d want 3", acc_log.size()); end
    n_cmp++; if (b_ch.size() != 8) begin n_fail++; $display("FAIL zmask_beats got %0d want 8", b_ch.size()); end
    for (int i = 0; i < 8 && i < b_ch.size(); i++) begin
      n_cmp++;
      if (b_ch[i] != i % 4 || b_data[i] !== 8'(i * 8'h11) || b_cyc[i] != b_cyc[0] + i) begin
        n_fail++; $display("FAIL zmask_beat%0d got ch=%0d d=%h want ch=%0d d=%h", i, b_ch[i], b_data[i], i % 4, 8'(i * 8'h11));
      end
    end
    n_cmp++; if (frames_sent !== f0 + 16'd2) begin n_fail++; $display("FAIL zmask_frames got %0d want %0d", frames_sent, f0 + 16'd2); end
  endtask

  task automatic test_mid_reset();
    fq_data.push_back(32'h0D0C0B0A); fq_mask.push_back(4'hF);
    run(50, 0, 2);
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd2) begin
      n_fail++; $display("FAIL mid_pre got v=%b ch=%0d want v=1 ch=2", out_valid, out_ch); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_ctrl got v=%b b=%b r=%b want 0 0 1", out_valid, busy, in_ready); end
    n_cmp++; if (out_data !== 8'h00 || out_ch !== 2'd0 || out_first !== 1'b0 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_data got d=%h ch=%0d f=%b l=%b want 00 0 0 0", out_data, out_ch, out_first, out_last); end
    n_cmp++; if (frames_sent !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_frames got %h want 0000", frames_sent); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    fq_data.push_back(32'h4D3C2B1A); fq_mask.push_back(4'hF);
    run(50, 0, 0);
    n_cmp++; if (b_ch.size() != 4 || b_ch[0] != 0 || b_data[0] !== 8'h1A || b_first[0] !== 1'b1) begin
      n_fail++; $display("FAIL mid_restart got beats=%0d want 4 starting ch0 d=1a first", b_ch.size()); end
    n_cmp++; if (b_ch.size() == 4 && (b_data[3] !== 8'h4D || b_last[3] !== 1'b1)) begin
      n_fail++; $display("FAIL mid_restart_last got d=%h l=%b want 4d 1", b_data[3], b_last[3]); end
    n_cmp++; if (frames_sent !== 16'd1) begin n_fail++; $display("FAIL mid_frames got %0d want 1", frames_sent); end
  endtask

  task automatic test_wrap();
    bit wrapped;
    logic fl;
    logic [15:0] prev;
    int k;
    wrapped = 1'b0; fl = 1'b0; prev = frames_sent;
    in_valid = 1'b1; in_data = 32'h000000EE; ch_mask = 4'b0001; out_ready = 1'b1;
    for (int i = 0; i < 70000 && !wrapped; i++) begin
      @(negedge clk);
      cyc++;
      if (frames_sent == 16'h0000 && prev == 16'hFFFF) begin
        wrapped = 1'b1;
        fl = out_valid && out_first && out_last && (out_data == 8'hEE);
      end
      prev = frames_sent;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; ch_mask = '0; in_data = '0;
    n_cmp++; if (!wrapped) begin n_fail++; $display("FAIL wrap_seen got 0 want 1 (last %h)", prev); end
    n_cmp++; if (!fl) begin n_fail++; $display("FAIL wrap_single_first_last got 0 want 1"); end
    k = 0;
    while (busy && k < 20) begin @(posedge clk); #1; k++; end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_drain got busy=%b want 0", busy); end
    n_cmp++; if (frames_sent !== 16'd2) begin n_fail++; $display("FAIL wrap_after got %0d want 2", frames_sent); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mask1010();
    test_back_to_back();
    test_stall();
    test_zero_mask();
    test_mid_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nchan_serializer.md
# nchan_serializer

Parametrised N-channel, W-bit parallel-to-serial converter with valid/ready handshakes on both sides, a one-frame holding buffer, and per-frame channel masking. It replaces the fixed two-input, divided-clock serializer pair with a single-clock block. The output rate is throttled by downstream `out_ready` instead of a derived clock. It sits between parallel sample producers and a narrow serial link or framer.

## Interface
- NUM_CH, 4, channel count; legal 2..16
- WIDTH, 8, bits per channel word and per output beat; legal 1..32
- CW, $clog2(NUM_CH), derived local; channel index width
- clk  input  1  sole clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  frame offered
- in_ready  output  1  frame accepted on in_valid && in_ready
- in_data  input  NUM_CH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- ch_mask  input  NUM_CH  bit k=1: channel k is sent; sampled with the frame
- out_valid  output  1  beat valid
- out_ready  input  1  beat consumed on out_valid && out_ready
- out_data  output  WIDTH  current channel word
- out_ch  output  CW  index of current channel
- out_first  output  1  first enabled channel of the frame
- out_last  output  1  last enabled channel of the frame
- busy  output  1  active frame or held frame present
- frames_sent  output  16  count of completed frames; wraps

## Operation
- Two frame registers, each holding data and mask:
  - ACTIVE: the frame being serialized.
  - HOLD: the next frame.
- States:
  - IDLE: ACTIVE empty.
  - SEND: ACTIVE loaded.
- in_ready = !hold_full. It is a registered-state function only; it has no combinational path from in_valid or out_ready.
- Accept in IDLE with hold empty: the frame loads directly into ACTIVE; next state is SEND.
- Accept in SEND: the frame loads into HOLD; hold_full is set.
- A frame with ch_mask == 0 is accepted and discarded. It produces no beats, does not occupy ACTIVE or HOLD, and does not count in frames_sent.
- In SEND, out_ch starts at the lowest set mask bit and steps on each handshake to the next higher set bit. Unset channels are skipped with zero cycles consumed.
- out_data = ACTIVE word[out_ch]. It is a mux from registered state.
- out_first = 1 when out_ch is the lowest set bit.
- out_last = 1 when no set bit exists above out_ch. With a single-bit mask, first and last are asserted together.
- Handshake on an out_last beat:
  - frames_sent increments, wrapping 0xFFFF -> 0x0000.
  - If HOLD is full, HOLD moves to ACTIVE and hold_full clears; state stays SEND.
  - Else if an input frame is accepted in the same cycle, it loads directly into ACTIVE; state stays SEND.
  - Else the state goes to IDLE.
- out_valid = (state == SEND).
- Outputs hold stable while out_valid && !out_ready.
- busy = (state == SEND) || hold_full.
- Reset mid-frame: both frames are discarded immediately and the counter clears. No partial beat completes.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, busy = 0.
  - out_data = 0, out_ch = 0, out_first = 0, out_last = 0.
  - frames_sent = 0.
- Latency: a frame accepted at edge t while IDLE gives out_valid = 1 with its first beat from cycle t+1.
- Throughput with out_ready held high:
  - One beat per cycle, with no bubble between back-to-back frames.
  - The first beat of the next frame appears the cycle after the previous out_last handshake.
- in_ready deasserts the cycle after HOLD fills. It reasserts the cycle after the out_last handshake that drains HOLD.
- The input must hold in_valid and in_data stable until accepted. The output side obeys the same rule.

## Test plan
- Reset release, then accept one frame, NUM_CH=4, WIDTH=8, data {0x44,0x33,0x22,0x11}, mask 0xF, out_ready=1:
  - Cycles t+1..t+4 show out_ch 0,1,2,3 and data 0x11,0x22,0x33,0x44.
  - first at beat 0, last at beat 3.
  - frames_sent = 1, then IDLE.
- Mask 0b1010:
  - Exactly two beats, ch1 then ch3, with no gap cycles.
  - first is on ch1; last is on ch3.
- Three frames offered back-to-back with out_ready=1:
  - in_ready drops after HOLD fills and the third frame waits.
  - 12 contiguous beats are output; frames_sent = 3.
- Random out_ready stalls (50%) on a mask-0xF frame:
  - out_data and out_ch are stable while stalled.
  - No beat is lost or duplicated.
- Mask 0x0 frame between two full frames: it is accepted and produces zero beats; frames_sent = 2.
- Mid-frame and wrap checks:
  - Assert reset after beat 1 of a frame: all outputs return to their reset values asynchronously, and the next frame starts cleanly at ch0.
  - Preload frames_sent = 0xFFFF by running frames: it wraps to 0x0000.
